// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// master = producer/consumer side, slave = controller side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_busy;

  modport master (
    output i_in_valid, i_a, i_b, i_cin, i_out_ready,
    input  o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_busy
  );

  modport slave (
    input  i_in_valid, i_a, i_b, i_cin, i_out_ready,
    output o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial A+B+cin, LSB first through one full adder; result valid WIDTH cycles after accept.
// Operands accepted only in IDLE; result held in DONE until i_out_ready.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic s_bit;
  logic c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_in_valid) begin
            a_q        <= bus.i_a;
            b_q        <= bus.i_b;
            carry_q    <= bus.i_cin;
            cnt_q      <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_next;
          cnt_q   <= cnt_q + 1'b1;
          // Last bit: capture carry-out and MSB overflow; counter parks at 0 rather than wrapping.
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout_q      <= c_next;
            ovf_q       <= carry_q ^ c_next;
            cnt_q       <= '0;
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_sum       = sum_q;
  assign bus.o_cout      = cout_q;
  assign bus.o_ovf       = ovf_q;
endmodule
